uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo_pkg.sv | 22 ++
 rtl/uart_rx_fifo_byte_fifo.sv | 108 ++++++++++
 rtl/uart_rx_fifo.sv | 229 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_fifo_pkg.sv
// Shared types and constants for the UART receiver with byte FIFO.
package uart_rx_pkg;

  // Receive FSM states
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Bit positions inside a frame: start bit is index 0, stop bit is index 9
  localparam logic [3:0] START_IDX = 4'd0;
  localparam logic [3:0] STOP_IDX  = 4'd9;

  // Two-out-of-three vote used to decide each bit from three mid-bit samples
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo_byte_fifo.sv
// Byte FIFO with a registered head output. A push while full is accepted only
// when a pop happens in the same cycle; the head register is prefetched so the
// byte at the new read pointer is presented together with the updated count.
module byte_fifo #(
  parameter FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head_data,
  output logic                     full,
  output logic                     empty,
  output logic [FIFO_DEPTH_LOG2:0] count
);

  localparam int DEPTH = 2 ** FIFO_DEPTH_LOG2;

  typedef logic [FIFO_DEPTH_LOG2-1:0] ptr_t;
  typedef logic [FIFO_DEPTH_LOG2:0]   cnt_t;

  localparam cnt_t DEPTH_CNT = cnt_t'(DEPTH);

  logic [7:0] mem_r [DEPTH];
  ptr_t       wr_ptr_r;
  ptr_t       rd_ptr_r;
  cnt_t       count_r;
  logic [7:0] head_r;
  logic       full_r;
  logic       empty_r;

  logic       pop_eff_s;
  logic       push_eff_s;
  ptr_t       rd_nxt_s;
  ptr_t       wr_nxt_s;
  cnt_t       count_nxt_s;
  logic [7:0] head_nxt_s;

  // Qualify push/pop and compute next pointers, count and head byte
  always_comb begin
    pop_eff_s   = pop & (count_r != cnt_t'(0));
    push_eff_s  = push & ((count_r != DEPTH_CNT) | pop_eff_s);
    rd_nxt_s    = rd_ptr_r;
    wr_nxt_s    = wr_ptr_r;
    count_nxt_s = count_r;
    head_nxt_s  = 8'h00;
    if (pop_eff_s) begin
      rd_nxt_s = rd_ptr_r + ptr_t'(1);
    end else begin
      rd_nxt_s = rd_ptr_r;
    end
    if (push_eff_s) begin
      wr_nxt_s = wr_ptr_r + ptr_t'(1);
    end else begin
      wr_nxt_s = wr_ptr_r;
    end
    case ({push_eff_s, pop_eff_s})
      2'b10:   count_nxt_s = count_r + cnt_t'(1);
      2'b01:   count_nxt_s = count_r - cnt_t'(1);
      default: count_nxt_s = count_r;
    endcase
    // The new head may be the byte being written this very cycle
    if (count_nxt_s == cnt_t'(0)) begin
      head_nxt_s = 8'h00;
    end else if (push_eff_s && (wr_ptr_r == rd_nxt_s)) begin
      head_nxt_s = push_data;
    end else begin
      head_nxt_s = mem_r[rd_nxt_s];
    end
  end

  // Storage array write
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 8'h00;
      end
    end else if (push_eff_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and registered status/head outputs
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      head_r   <= 8'h00;
      full_r   <= 1'b0;
      empty_r  <= 1'b1;
    end else begin
      wr_ptr_r <= wr_nxt_s;
      rd_ptr_r <= rd_nxt_s;
      count_r  <= count_nxt_s;
      head_r   <= head_nxt_s;
      full_r   <= (count_nxt_s == DEPTH_CNT);
      empty_r  <= (count_nxt_s == cnt_t'(0));
    end
  end

  assign head_data = head_r;
  assign full      = full_r;
  assign empty     = empty_r;
  assign count     = count_r;

endmodule

// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver with 3-sample majority voting feeding a small byte FIFO.
// A start is recognised one cycle early from the first synchronizer flop, so the
// cycle in which the synchronized line first reads low is already START tick 0.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter UART_CLK_TICKS_PER_BIT = 5'd20,
  parameter UART_CLK_TICKS_WIDTH   = 3'd5,
  parameter FIFO_DEPTH_LOG2        = 2
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     rx_in,
  output logic [7:0]               data_out,
  output logic                     data_valid,
  input  logic                     data_ready,
  output logic                     rx_running,
  output logic                     frame_error,
  output logic                     overflow,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count
);

  typedef logic [UART_CLK_TICKS_WIDTH-1:0] tick_t;

  localparam tick_t TICK_LAST   = tick_t'(UART_CLK_TICKS_PER_BIT - 1);
  localparam tick_t TICK_MID    = tick_t'(UART_CLK_TICKS_PER_BIT >> 1);
  localparam tick_t TICK_MID_M1 = TICK_MID - tick_t'(1);
  localparam tick_t TICK_MID_P1 = TICK_MID + tick_t'(1);

  logic       rx_meta_r;
  logic       rx_sync_r;
  logic [1:0] sync_ok_r;
  logic       armed_r;
  rx_state_e  state_r;
  tick_t      tick_r;
  logic [3:0] bit_idx_r;
  logic [7:0] shift_r;
  logic       samp_lo_r;
  logic       samp_mid_r;
  logic       rx_running_r;
  logic       frame_error_r;
  logic       overflow_r;

  rx_state_e  state_nxt_s;
  tick_t      tick_nxt_s;
  logic [3:0] bit_idx_nxt_s;
  logic [7:0] shift_nxt_s;
  logic       samp_lo_nxt_s;
  logic       samp_mid_nxt_s;
  logic       push_s;
  logic       frame_err_s;
  logic       start_edge_s;
  logic       decide_s;
  logic       tick_wrap_s;
  logic       bit_val_s;
  logic       fifo_full_s;
  logic       fifo_empty_s;

  // Two-flop synchronizer; both flops idle high so reset does not look like a start
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_meta_r <= 1'b1;
      rx_sync_r <= 1'b1;
    end else begin
      rx_meta_r <= rx_in;
      rx_sync_r <= rx_meta_r;
    end
  end

  // Arm the start detector only after a genuinely sampled high synchronized line
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      sync_ok_r <= 2'b00;
      armed_r   <= 1'b0;
    end else begin
      sync_ok_r <= {sync_ok_r[0], 1'b1};
      armed_r   <= armed_r | (sync_ok_r[1] & rx_sync_r);
    end
  end

  // Next-state, bit timing, sampling and shift logic of the receive FSM
  always_comb begin
    state_nxt_s    = state_r;
    tick_nxt_s     = tick_r;
    bit_idx_nxt_s  = bit_idx_r;
    shift_nxt_s    = shift_r;
    samp_lo_nxt_s  = samp_lo_r;
    samp_mid_nxt_s = samp_mid_r;
    push_s         = 1'b0;
    frame_err_s    = 1'b0;
    start_edge_s   = armed_r & rx_sync_r & ~rx_meta_r;
    decide_s       = (tick_r == TICK_MID_P1);
    tick_wrap_s    = (tick_r == TICK_LAST);
    bit_val_s      = majority3(samp_lo_r, samp_mid_r, rx_sync_r);

    if (state_r inside {START, DATA, STOP}) begin
      if (tick_wrap_s) begin
        tick_nxt_s    = tick_t'(0);
        bit_idx_nxt_s = bit_idx_r + 4'd1;
      end else begin
        tick_nxt_s    = tick_r + tick_t'(1);
        bit_idx_nxt_s = bit_idx_r;
      end
      if (tick_r == TICK_MID_M1) begin
        samp_lo_nxt_s = rx_sync_r;
      end else if (tick_r == TICK_MID) begin
        samp_mid_nxt_s = rx_sync_r;
      end else begin
        samp_lo_nxt_s  = samp_lo_r;
        samp_mid_nxt_s = samp_mid_r;
      end
    end else begin
      tick_nxt_s    = tick_t'(0);
      bit_idx_nxt_s = START_IDX;
    end

    case (state_r)
      IDLE: begin
        if (start_edge_s) begin
          state_nxt_s = START;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      START: begin
        if (decide_s && bit_val_s) begin
          state_nxt_s   = IDLE;
          tick_nxt_s    = tick_t'(0);
          bit_idx_nxt_s = START_IDX;
        end else if (tick_wrap_s) begin
          state_nxt_s = DATA;
        end else begin
          state_nxt_s = START;
        end
      end
      DATA: begin
        if (decide_s) begin
          shift_nxt_s = {bit_val_s, shift_r[7:1]};
        end else begin
          shift_nxt_s = shift_r;
        end
        if (tick_wrap_s && (bit_idx_r == STOP_IDX - 4'd1)) begin
          state_nxt_s = STOP;
        end else begin
          state_nxt_s = DATA;
        end
      end
      STOP: begin
        if (decide_s) begin
          tick_nxt_s    = tick_t'(0);
          bit_idx_nxt_s = START_IDX;
          if (bit_val_s) begin
            push_s      = 1'b1;
            state_nxt_s = IDLE;
          end else begin
            frame_err_s = 1'b1;
            state_nxt_s = WAIT_HIGH;
          end
        end else begin
          state_nxt_s = STOP;
        end
      end
      WAIT_HIGH: begin
        if (rx_sync_r) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WAIT_HIGH;
        end
      end
      default: begin
        state_nxt_s   = IDLE;
        tick_nxt_s    = tick_t'(0);
        bit_idx_nxt_s = START_IDX;
      end
    endcase
  end

  // Receive FSM state, counters and data registers
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_r    <= IDLE;
      tick_r     <= tick_t'(0);
      bit_idx_r  <= START_IDX;
      shift_r    <= 8'h00;
      samp_lo_r  <= 1'b1;
      samp_mid_r <= 1'b1;
    end else begin
      state_r    <= state_nxt_s;
      tick_r     <= tick_nxt_s;
      bit_idx_r  <= bit_idx_nxt_s;
      shift_r    <= shift_nxt_s;
      samp_lo_r  <= samp_lo_nxt_s;
      samp_mid_r <= samp_mid_nxt_s;
    end
  end

  // Registered status outputs; overflow only when the push finds no room
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_running_r  <= 1'b0;
      frame_error_r <= 1'b0;
      overflow_r    <= 1'b0;
    end else begin
      rx_running_r  <= (state_nxt_s != IDLE);
      frame_error_r <= frame_err_s;
      overflow_r    <= push_s & fifo_full_s & ~(data_ready & ~fifo_empty_s);
    end
  end

  byte_fifo #(
    .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)
  ) u_byte_fifo (
    .clk_in    (clk_in),
    .reset     (reset),
    .push      (push_s),
    .push_data (shift_r),
    .pop       (data_ready),
    .head_data (data_out),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count)
  );

  assign data_valid  = ~fifo_empty_s;
  assign rx_running  = rx_running_r;
  assign frame_error = frame_error_r;
  assign overflow    = overflow_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo at 20 clocks per bit and a 4-deep FIFO.
module tb_uart_rx_fifo;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       rx_in;
  logic       data_ready;
  logic [7:0] data_out;
  logic       data_valid;
  logic       rx_running;
  logic       frame_error;
  logic       overflow;
  logic [2:0] fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int fe_cnt   = 0;
  int ovf_cnt  = 0;

  uart_rx_fifo dut (
    .clk_in      (clk_in),
    .reset       (reset),
    .rx_in       (rx_in),
    .data_out    (data_out),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .rx_running  (rx_running),
    .frame_error (frame_error),
    .overflow    (overflow),
    .fifo_count  (fifo_count)
  );

  always #5 clk_in = ~clk_in;

  // Count one-cycle event pulses
  always @(posedge clk_in) begin
    if (frame_error) fe_cnt <= fe_cnt + 1;
    if (overflow) ovf_cnt <= ovf_cnt + 1;
  end

  // Drive one 10-bit frame, one bit per 20 clocks, starting just after an edge.
  // pop_at raises data_ready during that cycle index (cycle 0 = start bit begins).
  task automatic send_frame(input logic [7:0] d, input logic stop_b, input int pop_at,
                            output int rise_n, output int run_gap);
    logic [9:0] frame;
    logic       prev_v;
    frame   = {stop_b, d, 1'b0};
    rise_n  = -1;
    run_gap = 0;
    @(posedge clk_in); #1;
    rx_in      = frame[0];
    data_ready = 1'b0;
    prev_v     = data_valid;
    for (int n = 1; n < 200; n++) begin
      @(posedge clk_in); #1;
      rx_in      = frame[n / 20];
      data_ready = (n == pop_at);
      if (data_valid && !prev_v && rise_n < 0) rise_n = n;
      prev_v = data_valid;
      if (n >= 2 && n <= 193 && !rx_running) run_gap++;
    end
    @(posedge clk_in); #1;
    rx_in      = stop_b;
    data_ready = 1'b0;
    if (data_valid && !prev_v && rise_n < 0) rise_n = 200;
  endtask

  // Capture the head then pop it
  task automatic pop_byte(output logic [7:0] d, output logic v);
    v          = data_valid;
    d          = data_out;
    data_ready = 1'b1;
    @(posedge clk_in); #1;
    data_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rx_in = 1'b1; data_ready = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", data_out); end
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL reset_data_valid: got %b expected 0", data_valid); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_fifo_count: got %0d expected 0", fifo_count); end
    n_checks++; if (rx_running !== 1'b0) begin n_fail++; $display("FAIL reset_rx_running: got %b expected 0", rx_running); end
    n_checks++; if (frame_error !== 1'b0 || overflow !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: got fe=%b ovf=%b expected 0 0", frame_error, overflow); end
    reset = 1'b0;
    repeat (5) @(posedge clk_in);
    #1;
    n_checks++; if (rx_running !== 1'b0) begin n_fail++; $display("FAIL post_reset_idle: got %b expected 0", rx_running); end
  endtask

  task automatic test_single_byte();
    int rise, gap;
    logic [7:0] d; logic v;
    send_frame(8'h65, 1'b1, -1, rise, gap);
    n_checks++; if (rise !== 194) begin n_fail++; $display("FAIL latency: got %0d expected 194", rise); end
    n_checks++; if (gap !== 0) begin n_fail++; $display("FAIL rx_running_frame: got %0d low cycles expected 0", gap); end
    n_checks++; if (data_out !== 8'h65) begin n_fail++; $display("FAIL single_data: got %h expected 65", data_out); end
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL single_count: got %0d expected 1", fifo_count); end
    n_checks++; if (rx_running !== 1'b0) begin n_fail++; $display("FAIL single_idle: got %b expected 0", rx_running); end
    pop_byte(d, v);
    n_checks++; if (data_valid !== 1'b0) begin n_fail++; $display("FAIL single_pop_empty: got %b expected 0", data_valid); end
  endtask

  task automatic test_overflow();
    logic [7:0] vals [5];
    int rise, gap, ovf0;
    logic [7:0] d; logic v;
    vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    ovf0 = ovf_cnt;
    for (int i = 0; i < 4; i++) send_frame(vals[i], 1'b1, -1, rise, gap);
    n_checks++; if (ovf_cnt - ovf0 !== 0) begin n_fail++; $display("FAIL ovf_early: got %0d expected 0", ovf_cnt - ovf0); end
    send_frame(vals[4], 1'b1, -1, rise, gap);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL ovf_count: got %0d expected 4", fifo_count); end
    n_checks++; if (ovf_cnt - ovf0 !== 1) begin n_fail++; $display("FAIL ovf_pulses: got %0d expected 1", ovf_cnt - ovf0); end
    for (int i = 0; i < 4; i++) begin
      pop_byte(d, v);
      n_checks++; if (v !== 1'b1 || d !== vals[i]) begin n_fail++; $display("FAIL ovf_pop%0d: got v=%b %h expected 1 %h", i, v, d, vals[i]); end
    end
    n_checks++; if (data_valid !== 1'b0 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL ovf_drained: got v=%b cnt=%0d expected 0 0", data_valid, fifo_count); end
  endtask

  task automatic test_full_simultaneous();
    logic [7:0] exp_q [4];
    int rise, gap, ovf0;
    logic [7:0] d; logic v;
    exp_q = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
    ovf0  = ovf_cnt;
    send_frame(8'hA1, 1'b1, -1, rise, gap);
    send_frame(8'hA2, 1'b1, -1, rise, gap);
    send_frame(8'hA3, 1'b1, -1, rise, gap);
    send_frame(8'hA4, 1'b1, -1, rise, gap);
    send_frame(8'hB5, 1'b1, 193, rise, gap);
    n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL full_simul_count: got %0d expected 4", fifo_count); end
    n_checks++; if (ovf_cnt - ovf0 !== 0) begin n_fail++; $display("FAIL full_simul_ovf: got %0d expected 0", ovf_cnt - ovf0); end
    for (int i = 0; i < 4; i++) begin
      pop_byte(d, v);
      n_checks++; if (v !== 1'b1 || d !== exp_q[i]) begin n_fail++; $display("FAIL full_simul_pop%0d: got v=%b %h expected 1 %h", i, v, d, exp_q[i]); end
    end
  endtask

  task automatic test_empty_simultaneous();
    int rise, gap;
    logic [7:0] d; logic v;
    pop_byte(d, v);
    n_checks++; if (fifo_count !== 3'd0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL empty_pop_ignored: got cnt=%0d v=%b expected 0 0", fifo_count, data_valid); end
    send_frame(8'h5A, 1'b1, 193, rise, gap);
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL empty_simul_count: got %0d expected 1", fifo_count); end
    n_checks++; if (data_out !== 8'h5A) begin n_fail++; $display("FAIL empty_simul_head: got %h expected 5a", data_out); end
    pop_byte(d, v);
  endtask

  task automatic test_frame_error();
    int rise, gap, fe0;
    fe0 = fe_cnt;
    send_frame(8'hA5, 1'b0, -1, rise, gap);
    n_checks++; if (fe_cnt - fe0 !== 1) begin n_fail++; $display("FAIL fe_pulse: got %0d expected 1", fe_cnt - fe0); end
    n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL fe_count: got %0d expected 0", fifo_count); end
    repeat (250) @(posedge clk_in);
    #1;
    n_checks++; if (rx_running !== 1'b1) begin n_fail++; $display("FAIL fe_wait_high: got %b expected 1", rx_running); end
    n_checks++; if (fe_cnt - fe0 !== 1 || fifo_count !== 3'd0) begin n_fail++; $display("FAIL fe_hold_low: got fe=%0d cnt=%0d expected 1 0", fe_cnt - fe0, fifo_count); end
    rx_in = 1'b1;
    repeat (5) @(posedge clk_in);
    #1;
    n_checks++; if (rx_running !== 1'b0) begin n_fail++; $display("FAIL fe_release: got %b expected 0", rx_running); end
  endtask

  task automatic test_glitch();
    int fe0;
    fe0 = fe_cnt;
    @(posedge clk_in); #1;
    rx_in = 1'b0;
    repeat (6) @(posedge clk_in);
    #1;
    rx_in = 1'b1;
    n_checks++; if (rx_running !== 1'b1) begin n_fail++; $display("FAIL glitch_start: got %b expected 1", rx_running); end
    repeat (30) @(posedge clk_in);
    #1;
    n_checks++; if (rx_running !== 1'b0) begin n_fail++; $display("FAIL glitch_idle: got %b expected 0", rx_running); end
    n_checks++; if (fifo_count !== 3'd0 || fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL glitch_no_output: got cnt=%0d fe=%0d expected 0 0", fifo_count, fe_cnt - fe0); end
  endtask

  task automatic test_reset_mid_frame();
    int rise, gap, fe0;
    logic [7:0] d; logic v;
    send_frame(8'h77, 1'b1, -1, rise, gap);
    n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL rst_pre_count: got %0d expected 1", fifo_count); end
    @(posedge clk_in); #1;
    rx_in = 1'b0;
    repeat (90) @(posedge clk_in);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk_in);
    #1;
    reset = 1'b0;
    fe0 = fe_cnt;
    repeat (250) @(posedge clk_in);
    #1;
    n_checks++; if (fifo_count !== 3'd0 || data_valid !== 1'b0) begin n_fail++; $display("FAIL rst_fifo_empty: got cnt=%0d v=%b expected 0 0", fifo_count, data_valid); end
    n_checks++; if (data_out !== 8'h00) begin n_fail++; $display("FAIL rst_data_out: got %h expected 00", data_out); end
    n_checks++; if (rx_running !== 1'b0) begin n_fail++; $display("FAIL rst_low_line_start: got %b expected 0", rx_running); end
    rx_in = 1'b1;
    repeat (20) @(posedge clk_in);
    send_frame(8'h3C, 1'b1, -1, rise, gap);
    n_checks++; if (fifo_count !== 3'd1 || data_out !== 8'h3C) begin n_fail++; $display("FAIL rst_recover: got cnt=%0d %h expected 1 3c", fifo_count, data_out); end
    n_checks++; if (fe_cnt - fe0 !== 0) begin n_fail++; $display("FAIL rst_no_fe: got %0d expected 0", fe_cnt - fe0); end
    pop_byte(d, v);
  endtask

  initial begin
    test_reset();
    test_single_byte();
    test_overflow();
    test_full_simultaneous();
    test_empty_simultaneous();
    test_frame_error();
    test_glitch();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
